// File: rtl/axis_upsizer_8to32.sv
// Packs 8-bit AXI-Stream beats little-endian into RATIO-byte words, keeping tkeep and tlast.
// Latency: one cycle from the completing beat. Input tready drops while the output word is stalled.
module axis_upsizer_8to32 #(
    parameter int RATIO = 4
) (
    input  logic               aclk,
    input  logic               areset,
    input  logic               s_axis_tvalid,
    output logic               s_axis_tready,
    input  logic [7:0]         s_axis_tdata,
    input  logic               s_axis_tkeep,
    input  logic               s_axis_tlast,
    output logic               m_axis_tvalid,
    input  logic               m_axis_tready,
    output logic [8*RATIO-1:0] m_axis_tdata,
    output logic [RATIO-1:0]   m_axis_tkeep,
    output logic               m_axis_tlast
);
    localparam int CW = $clog2(RATIO);

    logic [8*RATIO-1:0] acc_data_q, acc_data_d, word_data;
    logic [RATIO-1:0]   acc_keep_q, acc_keep_d, word_keep;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [8*RATIO-1:0] out_data_q, out_data_d;
    logic [RATIO-1:0]   out_keep_q, out_keep_d;
    logic               out_vld_q, out_vld_d;
    logic               out_last_q, out_last_d;
    logic               accept, complete;

    // The only path from the output side back to the input is this gate.
    assign s_axis_tready = !areset && !(out_vld_q && !m_axis_tready);
    assign accept        = s_axis_tvalid && s_axis_tready;

    always_comb begin
        acc_data_d = acc_data_q;
        acc_keep_d = acc_keep_q;
        cnt_d      = cnt_q;
        word_data  = acc_data_q;
        word_keep  = acc_keep_q;
        complete   = 1'b0;
        if (accept) begin
            if (s_axis_tkeep) begin
                word_data[8*cnt_q +: 8] = s_axis_tdata;
                word_keep[cnt_q]        = 1'b1;
                complete                = s_axis_tlast || (cnt_q == CW'(RATIO-1));
                cnt_d                   = cnt_q + 1'b1;
            end else begin
                complete = s_axis_tlast;
            end
            acc_data_d = word_data;
            acc_keep_d = word_keep;
        end
        if (complete) begin
            acc_data_d = '0;
            acc_keep_d = '0;
            cnt_d      = '0;
        end
    end

    always_comb begin
        out_vld_d  = out_vld_q;
        out_data_d = out_data_q;
        out_keep_d = out_keep_q;
        out_last_d = out_last_q;
        if (complete) begin
            out_vld_d  = 1'b1;
            out_data_d = word_data;
            out_keep_d = word_keep;
            out_last_d = s_axis_tlast;
        end else if (m_axis_tready) begin
            out_vld_d = 1'b0;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            acc_data_q <= '0;
            acc_keep_q <= '0;
            cnt_q      <= '0;
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
            out_keep_q <= '0;
            out_last_q <= 1'b0;
        end else begin
            acc_data_q <= acc_data_d;
            acc_keep_q <= acc_keep_d;
            cnt_q      <= cnt_d;
            out_vld_q  <= out_vld_d;
            out_data_q <= out_data_d;
            out_keep_q <= out_keep_d;
            out_last_q <= out_last_d;
        end
    end

    assign m_axis_tvalid = out_vld_q;
    assign m_axis_tdata  = out_data_q;
    assign m_axis_tkeep  = out_keep_q;
    assign m_axis_tlast  = out_last_q;
endmodule

// File: tb/tb_axis_upsizer_8to32.sv
// Scoreboarded bench for axis_upsizer_8to32: directed cases plus a randomized soak.
module tb_axis_upsizer_8to32;
    localparam int RATIO = 4;
    localparam int W     = 8*RATIO;

    logic           aclk, areset;
    logic           s_axis_tvalid, s_axis_tready, s_axis_tkeep, s_axis_tlast;
    logic [7:0]     s_axis_tdata;
    logic           m_axis_tvalid, m_axis_tready, m_axis_tlast;
    logic [W-1:0]   m_axis_tdata;
    logic [RATIO-1:0] m_axis_tkeep;

    typedef struct packed {
        logic [W-1:0]     d;
        logic [RATIO-1:0] k;
        logic             l;
    } word_t;

    word_t      exp_q[$];
    logic [7:0] pend[$];
    int checks   = 0;
    int failures = 0;
    int mode     = 0;   // 0: m_axis_tready high, 1: low, 2: random
    int cyc      = 0;
    int stalls   = 0;

    axis_upsizer_8to32 #(.RATIO(RATIO)) dut (
        .aclk          (aclk),
        .areset        (areset),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    always @(posedge aclk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: collect kept bytes per packet, emit a word when RATIO are held or on tlast.
    function automatic void model_beat(input logic [7:0] d, input logic k, input logic l);
        word_t w;
        if (k) pend.push_back(d);
        if ((k && pend.size() == RATIO) || l) begin
            w.d = '0;
            for (int i = 0; i < pend.size(); i++) w.d = w.d | (W'(pend[i]) << (8*i));
            w.k = RATIO'((1 << pend.size()) - 1);
            w.l = l;
            exp_q.push_back(w);
            pend.delete();
        end
    endfunction

    // Called at a falling edge; returns at the falling edge after the beat is accepted.
    task automatic send(input logic [7:0] d, input logic k, input logic l);
        int n   = 0;
        bit acc = 0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tlast  = l;
        while (!acc && n < 1000) begin
            #1;
            acc = s_axis_tready;
            if (!acc) stalls++;
            @(posedge aclk);
            n++;
            if (!acc) @(negedge aclk);
        end
        check("beat_accepted", acc, 1);
        if (acc) model_beat(d, k, l);
        @(negedge aclk);
        s_axis_tvalid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge aclk);
    endtask

    task automatic rst(input int n);
        @(negedge aclk);
        areset        = 1'b1;
        s_axis_tvalid = 1'b0;
        exp_q.delete();
        pend.delete();
        for (int i = 0; i < n; i++) begin
            #1;
            check("rst_s_tready", s_axis_tready, 0);
            @(negedge aclk);
        end
        areset = 1'b0;
        #1;
        check("rst_m_tvalid", m_axis_tvalid, 0);
        check("rst_m_tdata", m_axis_tdata, 0);
        check("rst_m_tkeep", m_axis_tkeep, 0);
        check("rst_m_tlast", m_axis_tlast, 0);
        @(negedge aclk);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(negedge aclk);
            n++;
        end
        check("drain_empty", exp_q.size(), 0);
        idle(4);
    endtask

    // Monitor: output handshake, invariants, and hold-stable during stalls.
    logic  prev_stall = 1'b0;
    word_t prev_w;
    initial begin
        word_t w;
        m_axis_tready = 1'b1;
        forever begin
            @(negedge aclk);
            m_axis_tready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'b0 : ($urandom_range(0, 9) < 7);
            #1;
            if (!areset) begin
                if (prev_stall) begin
                    check("hold_tvalid", m_axis_tvalid, 1);
                    check("hold_word", {m_axis_tdata, m_axis_tkeep, m_axis_tlast}, prev_w);
                end
                if (m_axis_tvalid) begin
                    check("keep_contig", ((m_axis_tkeep & (m_axis_tkeep + 1'b1)) == 0), 1);
                    check("partial_has_last", (m_axis_tkeep == '1) || m_axis_tlast, 1);
                end
                if (m_axis_tvalid && m_axis_tready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_word: got %0h with empty scoreboard", m_axis_tdata);
                    end else begin
                        w = exp_q.pop_front();
                        check("word_data", m_axis_tdata, w.d);
                        check("word_keep", m_axis_tkeep, w.k);
                        check("word_last", m_axis_tlast, w.l);
                    end
                end
                prev_stall = m_axis_tvalid && !m_axis_tready;
                prev_w     = {m_axis_tdata, m_axis_tkeep, m_axis_tlast};
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, s0;
        areset        = 1'b1;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tkeep  = 1'b0;
        s_axis_tlast  = 1'b0;
        rst(2);

        // Full words with latency and throughput checks
        mode = 0;
        c0 = cyc;
        s0 = stalls;
        for (int i = 1; i <= 8; i++) begin
            send(8'(i), 1'b1, i == 8);
            if (i == 4) begin
                #1;
                check("lat_vld_w0", m_axis_tvalid, 1);
                check("lat_data_w0", m_axis_tdata, 32'h04030201);
            end
            if (i == 8) begin
                #1;
                check("lat_vld_w1", m_axis_tvalid, 1);
                check("lat_data_w1", m_axis_tdata, 32'h08070605);
            end
        end
        check("throughput_cycles", cyc - c0, 8);
        check("no_input_stall", stalls - s0, 0);
        drain();

        // Partial tail
        send(8'hAA, 1'b1, 1'b0);
        send(8'hBB, 1'b1, 1'b0);
        send(8'hCC, 1'b1, 1'b1);
        drain();

        // Null beats, then an empty tlast-only word
        send(8'hAA, 1'b1, 1'b0);
        send(8'h00, 1'b0, 1'b0);
        send(8'hBB, 1'b1, 1'b0);
        send(8'h00, 1'b0, 1'b1);
        send(8'h00, 1'b0, 1'b1);
        drain();

        // Backpressure
        mode = 1;
        idle(1);
        fork
            for (int i = 0; i < 12; i++) send(8'(8'h10 + i), 1'b1, i == 11);
            begin
                idle(12);
                #1;
                check("bp_held_vld", m_axis_tvalid, 1);
                check("bp_held_data", m_axis_tdata, 32'h13121110);
                check("bp_s_tready", s_axis_tready, 0);
                mode = 0;
            end
        join
        drain();

        // Reset mid-packet
        send(8'h55, 1'b1, 1'b0);
        send(8'h66, 1'b1, 1'b0);
        rst(1);
        for (int i = 1; i <= 4; i++) send(8'(8'h20 + i), 1'b1, i == 4);
        drain();

        // Random soak
        mode = 2;
        for (int b = 0; b < 20; b++) begin
            for (int i = 0; i < 20; i++) begin
                idle($urandom_range(0, 2));
                send(8'($urandom), ($urandom_range(0, 4) != 0), (i == 19) || ($urandom_range(0, 7) == 0));
            end
        end
        mode = 0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
